// File: rtl/regfile_pkg.sv
// Shared register-file definitions: data width, register address width,
// the hard-wired zero register and the write-request record.
// Used by the register file, the forwarding unit and the write arbiter.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wr_req_t;

  // True when the destination is x0, which must never be written.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] rd);
    return (rd == ZERO_REG_ADDR);
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO buffering port-B write-back results.
// DEPTH must be a power of two so the pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (level_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage, wrapping pointers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + (PTR_W+1)'(1);
        2'b01:   level_q <= level_q - (PTR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-side initiator for the integer register file's single write port.
// Port A (in-order ALU) and port B (LSU / mul-div, FIFO-buffered) share one
// registered write port; a busy bitmap tracks outstanding port-B writes.
// Optional build macro WB_BYPASS_EN: a port-B result arriving while the
// FIFO is empty and port A is idle is written directly, skipping the FIFO.
import regfile_pkg::*;

module regfile_write_arbiter #(
  parameter int XLEN         = regfile_pkg::XLEN,
  parameter int REG_DEPTH    = 32,
  parameter int B_FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [4:0]                    a_rd,
  input  logic [XLEN-1:0]               a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [4:0]                    b_rd,
  input  logic [XLEN-1:0]               b_data,
  input  logic                          claim_valid,
  input  logic [4:0]                    claim_rd,
  output logic                          we,
  output logic [4:0]                    rd_addr,
  output logic [XLEN-1:0]               rd_wdata,
  output logic [REG_DEPTH-1:0]          busy,
  output logic [$clog2(B_FIFO_DEPTH):0] b_level
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;

  logic [ENTRY_W-1:0]    fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  bypass_s;
  logic                  grant_s;
  logic                  grant_b_s;
  logic [4:0]            grant_rd_s;
  logic [XLEN-1:0]       grant_data_s;
  logic                  we_d, we_q;
  logic [4:0]            rd_addr_q;
  logic [XLEN-1:0]       rd_wdata_q;
  logic [REG_DEPTH-1:0]  busy_d, busy_q;

`ifdef WB_BYPASS_EN
  assign bypass_s = fifo_empty_s && !a_valid && b_valid;
`else
  assign bypass_s = 1'b0;
`endif

  // A full FIFO takes priority over port A, so both ready signals track it.
  assign a_ready     = !fifo_full_s;
  assign b_ready     = !fifo_full_s;
  assign fifo_push_s = b_valid && b_ready && !bypass_s;

  wb_sync_fifo #(
    .DEPTH (B_FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_b_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .wdata_i ({b_rd, b_data}),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (b_level)
  );

  // Priority arbitration: full FIFO, then port A, then FIFO head, then bypass.
  always_comb begin
    grant_s      = 1'b0;
    grant_b_s    = 1'b0;
    fifo_pop_s   = 1'b0;
    grant_rd_s   = ZERO_REG_ADDR;
    grant_data_s = '0;
    if (fifo_full_s) begin
      grant_s      = 1'b1;
      grant_b_s    = 1'b1;
      fifo_pop_s   = 1'b1;
      grant_rd_s   = fifo_head_s[ENTRY_W-1:XLEN];
      grant_data_s = fifo_head_s[XLEN-1:0];
    end else if (a_valid) begin
      grant_s      = 1'b1;
      grant_rd_s   = a_rd;
      grant_data_s = a_data;
    end else if (!fifo_empty_s) begin
      grant_s      = 1'b1;
      grant_b_s    = 1'b1;
      fifo_pop_s   = 1'b1;
      grant_rd_s   = fifo_head_s[ENTRY_W-1:XLEN];
      grant_data_s = fifo_head_s[XLEN-1:0];
    end else if (bypass_s) begin
      grant_s      = 1'b1;
      grant_b_s    = 1'b1;
      grant_rd_s   = b_rd;
      grant_data_s = b_data;
    end else begin
      grant_s      = 1'b0;
    end
  end

  // Grants to x0 complete the handshake but never pulse the write enable.
  assign we_d = grant_s && !is_zero_reg(grant_rd_s);

  // Scoreboard next state: port-B grant clears, a new claim sets and wins.
  always_comb begin
    busy_d = busy_q;
    if (grant_b_s && !is_zero_reg(grant_rd_s)) begin
      busy_d[grant_rd_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (claim_valid && !is_zero_reg(claim_rd)) begin
      busy_d[claim_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Registered write port and scoreboard; address/data only load on a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      we_q   <= we_d;
      busy_q <= busy_d;
      if (we_d) begin
        rd_addr_q  <= grant_rd_s;
        rd_wdata_q <= grant_data_s;
      end
    end
  end

  assign we       = we_q;
  assign rd_addr  = rd_addr_q;
  assign rd_wdata = rd_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        claim_valid;
  logic [4:0]  claim_rd;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [31:0] busy;
  logic [1:0]  b_level;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .claim_valid (claim_valid),
    .claim_rd    (claim_rd),
    .we          (we),
    .rd_addr     (rd_addr),
    .rd_wdata    (rd_wdata),
    .busy        (busy),
    .b_level     (b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, ".we"}, 64'(we), 64'd1);
    check_eq({tag, ".rd"}, 64'(rd_addr), 64'(rd));
    check_eq({tag, ".data"}, 64'(rd_wdata), 64'(data));
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    claim_valid = 1'b0; claim_rd = 5'd0;
    tick(); tick();
    check_eq("rst.we", 64'(we), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.level", 64'(b_level), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("idle.b_ready", 64'(b_ready), 64'd1);
    check_eq("idle.a_ready", 64'(a_ready), 64'd1);

    // A-only stream
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEADBEEF;
    tick();
    check_wr("a0", 5'd3, 32'hDEADBEEF);
    a_rd = 5'd4; a_data = 32'h1;
    tick();
    check_wr("a1", 5'd4, 32'h1);
    a_valid = 1'b0;
    tick();
    check_eq("a.idle.we", 64'(we), 64'd0);

    // Claim r5, then a port-B result for r5
    claim_valid = 1'b1; claim_rd = 5'd5;
    tick();
    check_eq("claim5.busy", 64'(busy), 64'h20);
    claim_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd5; b_data = 32'h55;
    tick();
    b_valid = 1'b0;
`ifdef WB_BYPASS_EN
    check_wr("b5.byp", 5'd5, 32'h55);
    check_eq("b5.byp.busy", 64'(busy), 64'h0);
    check_eq("b5.byp.level", 64'(b_level), 64'd0);
`else
    check_eq("b5.q.we", 64'(we), 64'd0);
    check_eq("b5.q.level", 64'(b_level), 64'd1);
    check_eq("b5.q.busy", 64'(busy), 64'h20);
    tick();
    check_wr("b5.q", 5'd5, 32'h55);
    check_eq("b5.q.busy_clr", 64'(busy), 64'h0);
    check_eq("b5.q.level0", 64'(b_level), 64'd0);
`endif
    tick();
    check_eq("b5.after.we", 64'(we), 64'd0);

    // Continuous A with two B pushes: FIFO fills, head wins, then A resumes
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA0;
    b_valid = 1'b1; b_rd = 5'd20; b_data = 32'hB0;
    check_eq("fill.a_ready0", 64'(a_ready), 64'd1);
    tick();
    check_wr("fill.a10", 5'd10, 32'hA0);
    check_eq("fill.level1", 64'(b_level), 64'd1);
    a_rd = 5'd11; a_data = 32'hA1;
    b_rd = 5'd21; b_data = 32'hB1;
    check_eq("fill.b_ready1", 64'(b_ready), 64'd1);
    tick();
    check_wr("fill.a11", 5'd11, 32'hA1);
    check_eq("fill.level2", 64'(b_level), 64'd2);
    check_eq("fill.a_ready_full", 64'(a_ready), 64'd0);
    check_eq("fill.b_ready_full", 64'(b_ready), 64'd0);
    a_rd = 5'd12; a_data = 32'hA2;
    b_valid = 1'b0;
    tick();
    check_wr("fill.b20", 5'd20, 32'hB0);
    check_eq("fill.level_pop", 64'(b_level), 64'd1);
    check_eq("fill.a_ready_back", 64'(a_ready), 64'd1);
    tick();
    check_wr("fill.a12", 5'd12, 32'hA2);
    a_valid = 1'b0;
    tick();
    check_wr("fill.b21", 5'd21, 32'hB1);
    check_eq("fill.level_empty", 64'(b_level), 64'd0);
    tick();
    check_eq("fill.idle.we", 64'(we), 64'd0);

    // Same-cycle claim and port-B grant of r7: set wins
    claim_valid = 1'b1; claim_rd = 5'd7;
    tick();
    check_eq("c7.busy", 64'(busy), 64'h80);
    claim_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
    tick();
    check_eq("c7.x0.we", 64'(we), 64'd0);
    check_eq("c7.level", 64'(b_level), 64'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    claim_valid = 1'b1; claim_rd = 5'd7;
    tick();
    claim_valid = 1'b0;
    check_wr("c7.grant", 5'd7, 32'h77);
    check_eq("c7.busy_set_wins", 64'(busy), 64'h80);

    // x0 writes on both ports
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h1234;
    check_eq("x0.a_ready", 64'(a_ready), 64'd1);
    tick();
    check_eq("x0.a.we", 64'(we), 64'd0);
    a_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h99;
    check_eq("x0.b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
    check_eq("x0.b.we1", 64'(we), 64'd0);
    tick();
    check_eq("x0.b.we2", 64'(we), 64'd0);
    check_eq("x0.level", 64'(b_level), 64'd0);
    check_eq("x0.busy", 64'(busy), 64'h80);

    // Reset mid-stream with two FIFO entries and busy = 0x30 (plus r7)
    claim_valid = 1'b1; claim_rd = 5'd4;
    tick();
    claim_rd = 5'd5;
    tick();
    claim_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hC1;
    b_valid = 1'b1; b_rd = 5'd8; b_data = 32'hB8;
    tick();
    b_rd = 5'd9; b_data = 32'hB9;
    tick();
    b_valid = 1'b0;
    check_eq("mid.level2", 64'(b_level), 64'd2);
    check_eq("mid.busy", 64'(busy), 64'hB0);
    check_eq("mid.we", 64'(we), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid.rst.we", 64'(we), 64'd0);
    check_eq("mid.rst.rd", 64'(rd_addr), 64'd0);
    check_eq("mid.rst.data", 64'(rd_wdata), 64'd0);
    check_eq("mid.rst.busy", 64'(busy), 64'd0);
    check_eq("mid.rst.level", 64'(b_level), 64'd0);
    a_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("post.b_ready", 64'(b_ready), 64'd1);
    check_eq("post.level", 64'(b_level), 64'd0);
    check_eq("post.we", 64'(we), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
